// File: rtl/switch_led_ctrl.sv
// Switch-to-LED controller: per-channel synchroniser, debouncer, press pulse and
// four LED modes (follow, inverted, toggle, blink). Define SWLED_RELEASE_PULSE_EN to add release_pulse.
module switch_led_ctrl #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_HALF      = 6000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     sw_n,
  input  logic [2*N_CH-1:0]   mode,
  output logic [N_CH-1:0]     led,
  output logic [N_CH-1:0]     press_pulse
`ifdef SWLED_RELEASE_PULSE_EN
  ,
  output logic [N_CH-1:0]     release_pulse
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

  logic [N_CH-1:0]            sync1_r;
  logic [N_CH-1:0]            sync_n_r;
  logic [N_CH-1:0]            stable_r;
  logic [N_CH-1:0][CNT_W-1:0] cnt_r;
  logic [N_CH-1:0]            toggle_r;
  logic [BLK_W-1:0]           blk_cnt_r;
  logic                       phase_r;

  logic [N_CH-1:0]            stable_s;
  logic [N_CH-1:0][CNT_W-1:0] cnt_s;
  logic [N_CH-1:0]            press_s;
  logic [N_CH-1:0]            toggle_s;
  logic [N_CH-1:0]            led_s;
  logic [BLK_W-1:0]           blk_cnt_s;
  logic                       phase_s;
`ifdef SWLED_RELEASE_PULSE_EN
  logic [N_CH-1:0]            release_s;
`endif

  // Shared blink timebase: wraps at BLINK_HALF-1 and inverts the phase on wrap.
  always_comb begin
    blk_cnt_s = blk_cnt_r;
    phase_s   = phase_r;
    if (blk_cnt_r == BLK_LAST) begin
      blk_cnt_s = '0;
      phase_s   = ~phase_r;
    end else begin
      blk_cnt_s = blk_cnt_r + BLK_ONE;
    end
  end

  // Per-channel debounce, edge pulses, toggle state and LED mode selection.
  always_comb begin
    stable_s = stable_r;
    cnt_s    = cnt_r;
    press_s  = '0;
    toggle_s = toggle_r;
    led_s    = '0;
`ifdef SWLED_RELEASE_PULSE_EN
    release_s = '0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      if (sync_n_r[i] == stable_r[i]) begin
        cnt_s[i] = '0;
      end else if (cnt_r[i] == CNT_LAST) begin
        stable_s[i] = sync_n_r[i];
        cnt_s[i]    = '0;
        press_s[i]  = ~sync_n_r[i];
`ifdef SWLED_RELEASE_PULSE_EN
        release_s[i] = sync_n_r[i];
`endif
      end else begin
        cnt_s[i] = cnt_r[i] + CNT_ONE;
      end
      toggle_s[i] = toggle_r[i] ^ press_s[i];
      case (mode[2*i +: 2])
        2'b00:   led_s[i] = ~stable_r[i];
        2'b01:   led_s[i] = stable_r[i];
        2'b10:   led_s[i] = toggle_r[i];
        2'b11:   led_s[i] = toggle_r[i] & phase_r;
        default: led_s[i] = 1'b0;
      endcase
    end
  end

  // State and output registers; sync/stable reset to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r     <= '1;
      sync_n_r    <= '1;
      stable_r    <= '1;
      cnt_r       <= '0;
      toggle_r    <= '0;
      blk_cnt_r   <= '0;
      phase_r     <= 1'b0;
      led         <= '0;
      press_pulse <= '0;
    end else begin
      sync1_r     <= sw_n;
      sync_n_r    <= sync1_r;
      stable_r    <= stable_s;
      cnt_r       <= cnt_s;
      toggle_r    <= toggle_s;
      blk_cnt_r   <= blk_cnt_s;
      phase_r     <= phase_s;
      led         <= led_s;
      press_pulse <= press_s;
    end
  end

`ifdef SWLED_RELEASE_PULSE_EN
  // Release pulse register, same timing as press_pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      release_pulse <= '0;
    end else begin
      release_pulse <= release_s;
    end
  end
`endif

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Directed self-checking bench for switch_led_ctrl (N_CH=4, DEBOUNCE_CYCLES=4, BLINK_HALF=8).
module tb_switch_led_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_n;
  logic [7:0] mode;
  logic [3:0] led;
  logic [3:0] press_pulse;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_cnt;

  switch_led_ctrl #(
    .N_CH(4),
    .DEBOUNCE_CYCLES(4),
    .BLINK_HALF(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_n(sw_n),
    .mode(mode),
    .led(led),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  // Edges since reset release, used to predict the blink phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive sw at a negedge, then watch 7 negedges: pulse only after E5, LED checked after E6.
  task automatic window(input string tag, input logic [3:0] sw, input logic [3:0] pp_exp,
                        input logic [3:0] led_mask, input logic [3:0] led_exp);
    sw_n = sw;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      check({tag, "_pp"}, 32'(press_pulse), (k == 5) ? 32'(pp_exp) : 32'h0);
      if (k == 6) check({tag, "_led"}, 32'(led & led_mask), 32'(led_exp));
    end
  endtask

  initial begin
    int pulses;
    int pulse_k;
    logic [3:0] exp_led;

    // 1. reset and inverted-polarity follow mode
    rst_n = 1'b0;
    sw_n  = 4'hF;
    mode  = 8'b0101_0101;
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_pp", 32'(press_pulse), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("m01_first_edge", 32'(led), 32'hF);
    check("m01_pp", 32'(press_pulse), 32'h0);

    // 2. clean press and release in follow mode (toggle[0] -> 1)
    mode = 8'h00;
    window("press0", 4'hE, 4'h1, 4'h1, 4'h1);
    window("rel0", 4'hF, 4'h0, 4'h1, 4'h0);

    // 3. bounce on ch1: low E0-E2, high E3, low from E4
    sw_n    = 4'hD;
    pulses  = 0;
    pulse_k = -1;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (press_pulse[1]) begin
        pulses++;
        pulse_k = k;
      end
      check("bounce_other", 32'(press_pulse & 4'hD), 32'h0);
      sw_n = (k + 1 == 3) ? 4'hF : 4'hD;
    end
    check("bounce_count", 32'(pulses), 32'd1);
    check("bounce_when", 32'(pulse_k), 32'd9);
    check("bounce_led", 32'(led), 32'h2);
    window("rel1", 4'hF, 4'h0, 4'hF, 4'h0);

    // 4. toggle mode on ch2 (toggles: ch0=1 ch1=1 ch2=0 ch3=0)
    mode = 8'h20;
    window("tgl_p1", 4'hB, 4'h4, 4'hF, 4'h4);
    window("tgl_r1", 4'hF, 4'h0, 4'hF, 4'h4);
    window("tgl_p2", 4'hB, 4'h4, 4'hF, 4'h0);
    window("tgl_r2", 4'hF, 4'h0, 4'hF, 4'h0);

    // 5. simultaneous press ch0+ch3, ch3 blinking (toggle ch0 -> 0, ch3 -> 1)
    mode = 8'hC0;
    window("sim_p", 4'h6, 4'h9, 4'h1, 4'h1);
    window("sim_r", 4'hF, 4'h0, 4'h1, 4'h0);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      exp_led = {((edge_cnt - 1) / 8) % 2 == 1, 3'b000};
      check("blink", 32'(led), 32'(exp_led));
    end
    window("blk_p2", 4'h7, 4'h8, 4'h0, 4'h0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("blink_off", 32'(led), 32'h0);
    end

    // 6. reset at debounce count 2 with toggle[1]=1
    window("pre_rst", 4'hF, 4'h0, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    mode = 8'hAA;
    @(negedge clk);
    check("tgl_all", 32'(led), 32'h2);
    sw_n = 4'hE;
    repeat (4) @(negedge clk);
    check("pre_rst_pp", 32'(press_pulse), 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_led", 32'(led), 32'h0);
    check("mid_rst_pp", 32'(press_pulse), 32'h0);
    repeat (2) @(negedge clk);
    check("hold_rst_led", 32'(led), 32'h0);
    rst_n = 1'b1;
    window("requal", 4'hE, 4'h1, 4'hF, 4'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
